// File: rtl/jtag_chunk_sender.sv
// ============================================================================
// Module   : jtag_chunk_sender
// Purpose  : Serialises a wide frame into CHUNK_W-bit chunks (chunk 0 first)
//            with a four-phase iACK handshake. Optional XOR checksum chunk:
//            define JTAG_CHUNK_SENDER_CHECKSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module jtag_chunk_sender #(
   parameter int CHUNK_W    = 30,
   parameter int NUM_CHUNKS = 27,
   parameter int TOTAL_W    = 810,
   parameter int IDX_W      = 5
) (
   input  logic                 iCLK,
   input  logic                 iRESETn,
   input  logic                 iSTART,
   input  logic [TOTAL_W-1:0]   iDATA,
   input  logic                 iACK,
   output logic [CHUNK_W-1:0]   oDATA,
   output logic                 oVALID,
   output logic [IDX_W-1:0]     oCHUNK_IDX,
   output logic                 oBUSY,
   output logic                 oFINISH
);

   localparam int               SEL_W    = $clog2(TOTAL_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
`ifdef JTAG_CHUNK_SENDER_CHECKSUM_EN
   localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NUM_CHUNKS);
`endif

   generate
      if (TOTAL_W != CHUNK_W * NUM_CHUNKS) begin : g_badTotal
         $error("jtag_chunk_sender: TOTAL_W must equal CHUNK_W*NUM_CHUNKS");
      end
      if (NUM_CHUNKS >= (1 << IDX_W)) begin : g_badIdx
         $error("jtag_chunk_sender: IDX_W too narrow to hold NUM_CHUNKS");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      PRESENT = 3'd2,
      RELEASE = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t               r_state;
   logic [TOTAL_W-1:0]   r_frame;
   logic [IDX_W-1:0]     w_nextIdx;
   logic [CHUNK_W-1:0]   w_nextChunk;
`ifdef JTAG_CHUNK_SENDER_CHECKSUM_EN
   logic [CHUNK_W-1:0]   r_csum;
`endif

   // Guarded so the select never addresses past the end of the frame.
   always_comb begin
      w_nextIdx   = oCHUNK_IDX + 1'b1;
      w_nextChunk = '0;
      if (w_nextIdx <= LAST_IDX)
         w_nextChunk = r_frame[SEL_W'(w_nextIdx) * SEL_W'(CHUNK_W) +: CHUNK_W];
   end

   always_ff @(posedge iCLK) begin
      if (!iRESETn) begin
         r_state    <= IDLE;
         r_frame    <= '0;
         oDATA      <= '0;
         oVALID     <= 1'b0;
         oCHUNK_IDX <= '0;
         oBUSY      <= 1'b0;
         oFINISH    <= 1'b0;
`ifdef JTAG_CHUNK_SENDER_CHECKSUM_EN
         r_csum     <= '0;
`endif
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (iSTART) begin
                  r_frame    <= iDATA;
                  oFINISH    <= 1'b0;
                  oCHUNK_IDX <= '0;
                  oBUSY      <= 1'b1;
                  // A host still holding iACK must release it before chunk 0 appears.
                  if (!iACK) begin
                     oDATA   <= iDATA[CHUNK_W-1:0];
                     oVALID  <= 1'b1;
                     r_state <= PRESENT;
`ifdef JTAG_CHUNK_SENDER_CHECKSUM_EN
                     r_csum  <= iDATA[CHUNK_W-1:0];
`endif
                  end else begin
                     oVALID  <= 1'b0;
                     r_state <= ARM;
`ifdef JTAG_CHUNK_SENDER_CHECKSUM_EN
                     r_csum  <= '0;
`endif
                  end
               end
            end
            ARM: begin
               oVALID <= 1'b0;
               if (!iACK) begin
                  oDATA   <= r_frame[CHUNK_W-1:0];
                  oVALID  <= 1'b1;
                  r_state <= PRESENT;
`ifdef JTAG_CHUNK_SENDER_CHECKSUM_EN
                  r_csum  <= r_csum ^ r_frame[CHUNK_W-1:0];
`endif
               end
            end
            PRESENT: begin
               if (iACK) begin
                  oVALID  <= 1'b0;
                  r_state <= RELEASE;
               end
            end
            RELEASE: begin
               if (!iACK) begin
                  if (oCHUNK_IDX == LAST_IDX) begin
`ifdef JTAG_CHUNK_SENDER_CHECKSUM_EN
                     oCHUNK_IDX <= CSUM_IDX;
                     oDATA      <= r_csum;
                     oVALID     <= 1'b1;
                     r_state    <= PRESENT;
`else
                     oFINISH    <= 1'b1;
                     oBUSY      <= 1'b0;
                     r_state    <= DONE;
`endif
                  end
`ifdef JTAG_CHUNK_SENDER_CHECKSUM_EN
                  else if (oCHUNK_IDX == CSUM_IDX) begin
                     oFINISH    <= 1'b1;
                     oBUSY      <= 1'b0;
                     r_state    <= DONE;
                  end
`endif
                  else begin
                     oCHUNK_IDX <= w_nextIdx;
                     oDATA      <= w_nextChunk;
                     oVALID     <= 1'b1;
                     r_state    <= PRESENT;
`ifdef JTAG_CHUNK_SENDER_CHECKSUM_EN
                     r_csum     <= r_csum ^ w_nextChunk;
`endif
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
